// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register bank: stage indices,
// the bubble word, the stage record type and a small popcount helper.
package pipe_pkg;
    localparam int PIPE_XLEN = 32;

    localparam int STG_IFID  = 3;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 1;
    localparam int STG_MEMWB = 0;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]           inst;
        logic [PIPE_XLEN-1:0]  pc;
        logic                  valid;
    } stage_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: bubble beats enable, enable loads, else hold.
// Stages that carry no PC are built with PCW=1 and a tied-off pc input.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          PCW    = 32,
    parameter logic [31:0] BUBBLE = BUBBLE_INST
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_bubble,
    input  logic [31:0]    i_inst,
    input  logic [PCW-1:0] i_pc,
    input  logic           i_valid,
    output logic [31:0]    o_inst,
    output logic [PCW-1:0] o_pc,
    output logic           o_valid
);

    // Stage contents: bubble has priority over load even when enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_inst  <= BUBBLE;
            o_pc    <= {PCW{1'b0}};
            o_valid <= 1'b0;
        end else if (i_bubble) begin
            o_inst  <= BUBBLE;
            o_pc    <= {PCW{1'b0}};
            o_valid <= 1'b0;
        end else if (i_en) begin
            o_inst  <= i_inst;
            o_pc    <= i_pc;
            o_valid <= i_valid;
        end else begin
            o_inst  <= o_inst;
            o_pc    <= o_pc;
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/pipe_stage_bank.sv
// PC holder plus IF/ID, ID/EX, EX/MEM, MEM/WB registers driven by hazard-unit
// stall/flush commands. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_stage_bank
    import pipe_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [31:0]      BUBBLE   = BUBBLE_INST,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_next,
    input  logic [31:0]     inst_if,
    input  logic [3:0]      enable_ff,
    input  logic [3:0]      reset_ff,
    input  logic            enable_pc,
    input  logic [XLEN-1:0] data_wb,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst_id,
    output logic [31:0]     inst_ex,
    output logic [31:0]     inst_mem,
    output logic [31:0]     inst_wb,
    output logic [XLEN-1:0] pc_id,
    output logic [XLEN-1:0] pc_ex,
    output logic            valid_id,
    output logic            valid_ex,
    output logic            valid_mem,
    output logic            valid_wb,
    output logic [XLEN-1:0] data_wb_d1,
    output logic            stall_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    logic [0:0] w_exmem_pc_unused;
    logic [0:0] w_memwb_pc_unused;

    // Fetch PC: advances only when the hazard unit lets fetch proceed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (enable_pc) begin
            pc <= pc_next;
        end else begin
            pc <= pc;
        end
    end

    // Previous writeback datum and registered stall indication, always tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_wb_d1 <= {XLEN{1'b0}};
            stall_o    <= 1'b0;
        end else begin
            data_wb_d1 <= data_wb;
            stall_o    <= ~enable_pc;
        end
    end

    pipe_stage_reg #(.PCW(XLEN), .BUBBLE(BUBBLE)) u_ifid (
        .clk      (clk),
        .rst      (rst),
        .i_en     (enable_ff[STG_IFID]),
        .i_bubble (reset_ff[STG_IFID]),
        .i_inst   (inst_if),
        .i_pc     (pc),
        .i_valid  (1'b1),
        .o_inst   (inst_id),
        .o_pc     (pc_id),
        .o_valid  (valid_id)
    );

    pipe_stage_reg #(.PCW(XLEN), .BUBBLE(BUBBLE)) u_idex (
        .clk      (clk),
        .rst      (rst),
        .i_en     (enable_ff[STG_IDEX]),
        .i_bubble (reset_ff[STG_IDEX]),
        .i_inst   (inst_id),
        .i_pc     (pc_id),
        .i_valid  (valid_id),
        .o_inst   (inst_ex),
        .o_pc     (pc_ex),
        .o_valid  (valid_ex)
    );

    pipe_stage_reg #(.PCW(1), .BUBBLE(BUBBLE)) u_exmem (
        .clk      (clk),
        .rst      (rst),
        .i_en     (enable_ff[STG_EXMEM]),
        .i_bubble (reset_ff[STG_EXMEM]),
        .i_inst   (inst_ex),
        .i_pc     (1'b0),
        .i_valid  (valid_ex),
        .o_inst   (inst_mem),
        .o_pc     (w_exmem_pc_unused),
        .o_valid  (valid_mem)
    );

    pipe_stage_reg #(.PCW(1), .BUBBLE(BUBBLE)) u_memwb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (enable_ff[STG_MEMWB]),
        .i_bubble (reset_ff[STG_MEMWB]),
        .i_inst   (inst_mem),
        .i_pc     (1'b0),
        .i_valid  (valid_mem),
        .o_inst   (inst_wb),
        .o_pc     (w_memwb_pc_unused),
        .o_valid  (valid_wb)
    );

`ifdef PIPE_PERF_CNT_EN
    // Free-running wrap-around counters of stalled cycles and inserted bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (!enable_pc) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            bubble_cnt <= bubble_cnt + {29'd0, popcount4(reset_ff)};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed bench for pipe_stage_bank: fill, load-use stall, flush,
// bubble-over-enable, writeback delay and asynchronous reset mid-stall.
module tb_pipe_stage_bank;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next;
    logic [31:0] inst_if;
    logic [3:0]  enable_ff;
    logic [3:0]  reset_ff;
    logic        enable_pc;
    logic [31:0] data_wb;
    logic [31:0] pc;
    logic [31:0] inst_id, inst_ex, inst_mem, inst_wb;
    logic [31:0] pc_id, pc_ex;
    logic        valid_id, valid_ex, valid_mem, valid_wb;
    logic [31:0] data_wb_d1;
    logic        stall_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
    logic [31:0] exp_stall, exp_bub;
`endif

    int total;
    int bad;

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h00A0_0113;
    localparam logic [31:0] I2 = 32'h0000_A103;
    localparam logic [31:0] I3 = 32'h0020_8233;
    localparam logic [31:0] I4 = 32'h0031_02B3;
    localparam logic [31:0] I5 = 32'h0041_8333;
    localparam logic [31:0] I6 = 32'h0052_03B3;
    localparam logic [31:0] I7 = 32'h0062_8433;

    pipe_stage_bank dut (
        .clk        (clk),
        .rst        (rst),
        .pc_next    (pc_next),
        .inst_if    (inst_if),
        .enable_ff  (enable_ff),
        .reset_ff   (reset_ff),
        .enable_pc  (enable_pc),
        .data_wb    (data_wb),
        .pc         (pc),
        .inst_id    (inst_id),
        .inst_ex    (inst_ex),
        .inst_mem   (inst_mem),
        .inst_wb    (inst_wb),
        .pc_id      (pc_id),
        .pc_ex      (pc_ex),
        .valid_id   (valid_id),
        .valid_ex   (valid_ex),
        .valid_mem  (valid_mem),
        .valid_wb   (valid_wb),
        .data_wb_d1 (data_wb_d1),
        .stall_o    (stall_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
`ifdef PIPE_PERF_CNT_EN
        if (!rst) begin
            exp_stall = exp_stall + (enable_pc ? 32'd0 : 32'd1);
            exp_bub   = exp_bub + {28'd0, 4'(reset_ff[0]) + 4'(reset_ff[1])
                                          + 4'(reset_ff[2]) + 4'(reset_ff[3])};
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [3:0] bub, input logic epc,
                         input logic [31:0] inst, input logic [31:0] nxt);
        enable_ff = en;
        reset_ff  = bub;
        enable_pc = epc;
        inst_if   = inst;
        pc_next   = nxt;
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef PIPE_PERF_CNT_EN
        exp_stall = 32'd0;
        exp_bub   = 32'd0;
`endif
        rst = 1'b1;
        data_wb = 32'd0;
        drive(4'h0, 4'h0, 1'b1, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_inst_id", inst_id, 32'd0);
        check_eq("rst_inst_wb", inst_wb, 32'd0);
        check_eq("rst_valids", {28'd0, valid_id, valid_ex, valid_mem, valid_wb}, 32'd0);
        check_eq("rst_stall_o", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;

        // pipeline fill
        drive(4'hF, 4'h0, 1'b1, I0, 32'd4);
        step();
        check_eq("fill1_inst_id", inst_id, I0);
        check_eq("fill1_pc", pc, 32'd4);
        check_eq("fill1_valid", {28'd0, valid_id, valid_ex, valid_mem, valid_wb}, 32'h8);
        drive(4'hF, 4'h0, 1'b1, I1, 32'd8);
        step();
        check_eq("fill2_inst_ex", inst_ex, I0);
        check_eq("fill2_pc_id", pc_id, 32'd4);
        drive(4'hF, 4'h0, 1'b1, I2, 32'd12);
        step();
        check_eq("fill3_inst_mem", inst_mem, I0);
        check_eq("fill3_valid_wb", {31'd0, valid_wb}, 32'd0);
        check_eq("fill3_pc_ex", pc_ex, 32'd4);
        drive(4'hF, 4'h0, 1'b1, I3, 32'd16);
        step();
        check_eq("fill4_inst_wb", inst_wb, I0);
        check_eq("fill4_valid_wb", {31'd0, valid_wb}, 32'd1);
        check_eq("fill4_inst_ex", inst_ex, I2);

        // load-use stall
        drive(4'b0011, 4'b0010, 1'b0, I4, 32'h0000_0999);
        step();
        check_eq("lu_pc", pc, 32'd16);
        check_eq("lu_inst_id", inst_id, I3);
        check_eq("lu_inst_ex", inst_ex, I2);
        check_eq("lu_inst_mem", inst_mem, 32'd0);
        check_eq("lu_valid_mem", {31'd0, valid_mem}, 32'd0);
        check_eq("lu_inst_wb", inst_wb, I1);
        check_eq("lu_stall_o", {31'd0, stall_o}, 32'd1);
        drive(4'hF, 4'h0, 1'b1, I4, 32'd20);
        step();
        check_eq("post_lu_inst_id", inst_id, I4);
        check_eq("post_lu_inst_mem", inst_mem, I2);
        check_eq("post_lu_inst_wb", inst_wb, 32'd0);
        check_eq("post_lu_stall_o", {31'd0, stall_o}, 32'd0);

        // flush
        drive(4'hF, 4'b1100, 1'b1, I5, 32'h0000_0100);
        step();
        check_eq("fl_inst_id", inst_id, 32'd0);
        check_eq("fl_inst_ex", inst_ex, 32'd0);
        check_eq("fl_pc", pc, 32'h0000_0100);
        check_eq("fl_inst_mem", inst_mem, I3);
        check_eq("fl_inst_wb", inst_wb, I2);
        check_eq("fl_valid", {28'd0, valid_id, valid_ex, valid_mem, valid_wb}, 32'h3);

        // bubble over enable on MEM/WB
        drive(4'hF, 4'b0001, 1'b1, I6, 32'h0000_0104);
        step();
        check_eq("boe_inst_wb", inst_wb, 32'd0);
        check_eq("boe_valid_wb", {31'd0, valid_wb}, 32'd0);
        check_eq("boe_inst_id", inst_id, I6);
        check_eq("boe_pc_id", pc_id, 32'h0000_0100);

        // bubble with enable low, plus writeback delay
        drive(4'b0000, 4'b1000, 1'b0, I7, 32'h0000_0555);
        data_wb = 32'hDEAD_BEEF;
        step();
        check_eq("bnoen_inst_id", inst_id, 32'd0);
        check_eq("bnoen_pc", pc, 32'h0000_0104);
        check_eq("wb_d1_first", data_wb_d1, 32'hDEAD_BEEF);
        data_wb = 32'h1234_5678;
        drive(4'b1000, 4'b0000, 1'b0, I7, 32'h0000_0555);
        step();
        check_eq("wb_d1_second", data_wb_d1, 32'h1234_5678);
        check_eq("stall_load_id", inst_id, I7);
        drive(4'b0000, 4'b0000, 1'b0, I0, 32'h0000_0555);
        step();
`ifdef PIPE_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt, exp_stall);
        check_eq("bubble_cnt", bubble_cnt, exp_bub);
`endif

        // asynchronous reset in the middle of a stall
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_pc", pc, 32'd0);
        check_eq("arst_inst_id", inst_id, 32'd0);
        check_eq("arst_valids", {28'd0, valid_id, valid_ex, valid_mem, valid_wb}, 32'd0);
        check_eq("arst_d1", data_wb_d1, 32'd0);
        drive(4'b1000, 4'b0000, 1'b0, I5, 32'h0000_0777);
        step();
        check_eq("arst_hold_inst_id", inst_id, 32'd0);
        check_eq("arst_hold_stall_o", {31'd0, stall_o}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check_eq("arst_stall_cnt", stall_cnt, 32'd0);
        exp_stall = 32'd0;
        exp_bub   = 32'd0;
`endif
        rst = 1'b0;
        drive(4'hF, 4'h0, 1'b1, I1, 32'd4);
        step();
        check_eq("recover_inst_id", inst_id, I1);
        check_eq("recover_pc_id", pc_id, 32'd0);
        check_eq("recover_pc", pc, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
